// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared types and constants for the fetch front end: the fetch queue entry
// (PC + instruction word), the instruction width, and the privileged routine
// entry point used elsewhere in the core.
// -----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

    localparam int XLEN       = 64;
    localparam int INSN_WIDTH = 32;

    // Entry point of the privileged trap routine. The branch unit owns the
    // privilege check; the fetch unit treats it like any other redirect target.
    localparam logic [XLEN-1:0] PRIV_ROUTINE_START = 64'h0000_0000_0000_0100;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INSN_WIDTH-1:0] insn;
    } fetch_entry_t;

    // Instruction fetch is word based; any non-zero low bits are a fault.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundles the fetch unit's external traffic:
//   redirect_valid/redirect_pc      retire-time control-flow redirect
//   imem_req_valid/ready/addr       instruction memory request channel
//   imem_resp_valid/insn            in-order imem responses, no backpressure
//   dec_valid/ready/pc/insn         fetch queue head towards decode
//   misalign_fault                  fetch halted on a misaligned redirect
// master: the fetch unit. slave: the surrounding core / memory.
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if
    import fetch_pc_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 64
);
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic [INSN_WIDTH-1:0] imem_resp_insn;
    logic                  dec_valid;
    logic                  dec_ready;
    logic [DATA_WIDTH-1:0] dec_pc;
    logic [INSN_WIDTH-1:0] dec_insn;
    logic                  misalign_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_insn, dec_ready,
        output imem_req_valid, imem_req_addr, dec_valid,
               dec_pc, dec_insn, misalign_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_insn, dec_ready,
        input  imem_req_valid, imem_req_addr, dec_valid,
               dec_pc, dec_insn, misalign_fault
    );

endinterface

// File: rtl/fetch_pc_unit_fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_fetch_queue
// Synchronous FIFO of fetch entries with flush and occupancy output.
//   clk, rst_n     clock, async active-low reset (pointers/count only)
//   flush_i        drop all entries; push/pop in the same cycle are ignored
//   push_i/data_i  write an entry (caller guarantees a free slot)
//   pop_i          retire the head (caller guarantees non-empty)
//   head_o         head entry, valid when !empty_o
//   empty_o        queue empty
//   count_o        number of valid entries (0..DEPTH)
// Push and pop in the same cycle are legal at any occupancy, including full.
// -----------------------------------------------------------------------------
module fetch_pc_unit_fetch_queue
    import fetch_pc_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + AW'(1);
            if (pop_i)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Front-end PC generator and instruction fetch queue. Issues in-order word
// fetches from pc_q, tags returning instructions with resp_pc_q, buffers them
// in the fetch queue and presents the head to decode. A retire-time redirect
// flushes the queue, retargets both PCs and arranges for every request still
// in flight to be discarded when it returns.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          fetch_pc_unit_if.master (redirect, imem req/resp, decode,
//                misalign_fault)
// DATA_WIDTH must not exceed the package XLEN.
// -----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter int                    QUEUE_DEPTH     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master bus
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic                  fault_q, fault_d;

    logic [CNT_W-1:0]      q_count;
    logic [CNT_W:0]        credit_used;
    logic                  q_empty, q_push, q_pop;
    logic                  req_valid, req_fire, resp_drop;
    fetch_entry_t          push_entry, head_entry;

    // Credit scheme: a request is only issued when a queue slot is already
    // reserved for its response, because imem responses cannot be stalled.
    assign credit_used = {1'b0, outst_q} + {1'b0, q_count};
    assign req_valid   = rst_n && !fault_q && !bus.redirect_valid
                      && (outst_q < CNT_W'(MAX_OUTSTANDING))
                      && (credit_used < (CNT_W + 1)'(QUEUE_DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;

    // Wrong-path responses are discarded while drop_q is non-zero; one that
    // lands in the redirect cycle itself is discarded by not pushing it.
    assign resp_drop   = bus.imem_resp_valid && (drop_q != '0);
    assign q_push      = bus.imem_resp_valid && !resp_drop && !bus.redirect_valid;
    assign q_pop       = !q_empty && bus.dec_ready && !bus.redirect_valid;

    assign push_entry.pc   = XLEN'(resp_pc_q);
    assign push_entry.insn = bus.imem_resp_insn;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);
        drop_d    = drop_q;
        fault_d   = fault_q;
        if (bus.redirect_valid) begin
            pc_d      = bus.redirect_pc;
            resp_pc_d = bus.redirect_pc;
            // Everything still in flight after this cycle is wrong-path,
            // including anything left over from an earlier redirect.
            drop_d    = outst_q - CNT_W'(bus.imem_resp_valid);
            fault_d   = pc_misaligned(bus.redirect_pc[1:0]);
        end else begin
            if (req_fire)  pc_d      = pc_q + DATA_WIDTH'(4);
            if (q_push)    resp_pc_d = resp_pc_q + DATA_WIDTH'(4);
            if (resp_drop) drop_d    = drop_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            fault_q   <= fault_d;
        end
    end

    fetch_pc_unit_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.redirect_valid),
        .push_i  (q_push),
        .data_i  (push_entry),
        .pop_i   (q_pop),
        .head_o  (head_entry),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.dec_valid      = !q_empty;
    assign bus.dec_pc         = DATA_WIDTH'(head_entry.pc);
    assign bus.dec_insn       = head_entry.insn;
    assign bus.misalign_fault = fault_q;

    // A response with nothing in flight means the memory broke the protocol.
    a_resp_has_request: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.imem_resp_valid |-> (outst_q != '0)
    ) else $fatal(1, "imem response with no outstanding request");

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_pc_unit_if #(.DATA_WIDTH(64)) bus ();

    fetch_pc_unit #(
        .DATA_WIDTH      (64),
        .RESET_PC        (64'h1000),
        .MAX_OUTSTANDING (2),
        .QUEUE_DEPTH     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Instruction memory contents: a distinct word per address, so a response
    // labelled with the wrong PC shows up as an instruction mismatch.
    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [63:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    int unsigned cyc     = 0;
    int unsigned lat     = 0;
    bit          rnd_lat = 1'b0;

    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_insn  = '0;
    end

    always begin
        @(negedge clk);
        cyc++;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_insn  = imem_word(pend[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_insn  = '0;
        end
        #4;
        if (bus.imem_resp_valid) void'(pend.pop_front());
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready)
            pend.push_back('{bus.imem_req_addr,
                             cyc + 1 + (rnd_lat ? $urandom_range(0, 3) : lat)});
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input logic [63:0] base, input int n);
        logic [63:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = base + 64'(4 * i);
            exp_q.push_back('{pc, imem_word(pc)});
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (rst_n && bus.dec_valid && bus.dec_ready && !bus.redirect_valid) begin
            check("dec_expected_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dec_pc", bus.dec_pc, e.pc);
                check("dec_insn", 64'(bus.dec_insn), 64'(e.insn));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drain(input int limit, input bit rnd);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (exp_q.size() == 0 || n >= limit) break;
            bus.dec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) bus.imem_req_ready = 1'($urandom_range(0, 1));
            n++;
        end
        bus.dec_ready      = 1'b0;
        bus.imem_req_ready = 1'b1;
        if (exp_q.size() != 0) begin
            check("drain_entries_left", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int  req_cnt;
        bit  seen;

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #4;
        check("rst_imem_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("rst_misalign_fault", 64'(bus.misalign_fault), 64'd0);

        // 1: in-order fetch from RESET_PC
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("t1_first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t1_first_req_addr", bus.imem_req_addr, 64'h1000);
        push_exp(64'h1000, 3);
        drain(60, 1'b0);

        // 2: decode stalled, credit limit caps buffering, then release
        repeat (12) @(negedge clk);
        #4;
        check("t2_dec_valid_stalled", 64'(bus.dec_valid), 64'd1);
        check("t2_req_valid_full", 64'(bus.imem_req_valid), 64'd0);
        push_exp(64'h100C, 6);
        drain(60, 1'b0);

        // 3: two requests in flight, redirect drops both late responses
        bus.imem_req_ready = 1'b0;
        do_redirect(64'h1800);
        repeat (8) @(negedge clk);
        lat                = 5;
        bus.imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.imem_req_ready = 1'b0;
        #4;
        check("t3_outstanding_cap", 64'(bus.imem_req_valid), 64'd0);
        bus.imem_req_ready = 1'b1;
        do_redirect(64'h2000);
        lat = 0;
        push_exp(64'h2000, 3);
        drain(80, 1'b0);

        // 4: redirect coincides with a response, one more still in flight
        bus.imem_req_ready = 1'b0;
        do_redirect(64'h2800);
        repeat (10) @(negedge clk);
        lat                = 2;
        bus.imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.imem_req_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.imem_resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_resp_seen", 64'(seen), 64'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2400;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        lat = 0;
        push_exp(64'h2400, 3);
        drain(80, 1'b0);

        // 5: misaligned redirect halts fetch until an aligned redirect
        do_redirect(64'h2002);
        #1;
        check("t5_fault_set", 64'(bus.misalign_fault), 64'd1);
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #4;
            if (bus.imem_req_valid) req_cnt++;
        end
        check("t5_no_requests", 64'(req_cnt), 64'd0);
        check("t5_queue_empty", 64'(bus.dec_valid), 64'd0);
        do_redirect(64'h3000);
        #1;
        check("t5_fault_cleared", 64'(bus.misalign_fault), 64'd0);
        push_exp(64'h3000, 3);
        drain(80, 1'b0);

        // 6: PC wraps past the top of the address space, random timing
        rnd_lat = 1'b1;
        do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
        push_exp(64'hFFFF_FFFF_FFFF_FFF8, 12);
        drain(3000, 1'b1);
        rnd_lat = 1'b0;

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
